// File: rtl/player_motion_if.sv
//==============================================================================
// Module      : player_motion_if
// Description : Control, knockback-handshake and kinematic-output bundle for
//               one player_motion instance.
//               slave  - seen by the kinematics engine.
//               master - seen by whoever drives the controls (game logic/bench).
// Signals     : tick                            frame strobe
//               right,left,jump,squat,defend    level controls
//               kb_valid,kb_dir / kb_ready      knockback request / accept
//               x,y,vy                          signed position and velocity
//               isJ,isQ,isD,isK                 airborne/squat/defend/knocked
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface player_motion_if #(
   parameter int XW = 11,
   parameter int YW = 10
);
   logic                 tick;
   logic                 right;
   logic                 left;
   logic                 jump;
   logic                 squat;
   logic                 defend;
   logic                 kb_valid;
   logic                 kb_dir;
   logic                 kb_ready;
   logic signed [XW-1:0] x;
   logic signed [YW-1:0] y;
   logic signed [YW-1:0] vy;
   logic                 isJ;
   logic                 isQ;
   logic                 isD;
   logic                 isK;

   modport slave (
      input  tick, right, left, jump, squat, defend, kb_valid, kb_dir,
      output kb_ready, x, y, vy, isJ, isQ, isD, isK
   );

   modport master (
      output tick, right, left, jump, squat, defend, kb_valid, kb_dir,
      input  kb_ready, x, y, vy, isJ, isQ, isD, isK
   );
endinterface

`default_nettype wire

// File: rtl/player_motion.sv
//==============================================================================
// Module      : player_motion
// Description : Per-player kinematics engine. Holds x, y and vy and advances
//               them once per frame tick through walking, jumping, squatting,
//               defending and knockback. Instantiate once per player.
// Ports       : clk    - system clock
//               rst_n  - asynchronous active-low reset
//               bus    - player_motion_if.slave (controls, knockback
//                        handshake, position/velocity and status flags)
// Options     : DOUBLE_JUMP_EN - when defined, allows one extra jump per
//               airborne period.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module player_motion #(
   parameter int XW       = 11,
   parameter int YW       = 10,
   parameter int X_MIN    = -300,
   parameter int X_MAX    = 300,
   parameter int Y_GND    = -200,
   parameter int STEP_X   = 4,
   parameter int V_JUMP   = 12,
   parameter int G        = 1,
   parameter int KB_STEP  = 6,
   parameter int KB_TICKS = 8
)(
   input  wire logic        clk,
   input  wire logic        rst_n,
   player_motion_if.slave   bus
);

   // Guard-bit widths used for overflow-free intermediate arithmetic
   localparam int XG = XW + 1;
   localparam int YG = YW + 1;
   localparam int KW = (KB_TICKS < 2) ? 1 : $clog2(KB_TICKS + 1);

   localparam logic signed [XW-1:0] c_x_min     = XW'(X_MIN);
   localparam logic signed [XW-1:0] c_x_max     = XW'(X_MAX);
   localparam logic signed [XG-1:0] c_x_min_g   = XG'(X_MIN);
   localparam logic signed [XG-1:0] c_x_max_g   = XG'(X_MAX);
   localparam logic signed [XG-1:0] c_step_x    = XG'(STEP_X);
   localparam logic signed [XG-1:0] c_kb_step   = XG'(KB_STEP);
   localparam logic signed [XG-1:0] c_zero_xg   = '0;

   localparam logic signed [YW-1:0] c_y_gnd     = YW'(Y_GND);
   localparam logic signed [YW-1:0] c_v_jump    = YW'(V_JUMP);
   localparam logic signed [YW-1:0] c_zero_y    = '0;
   localparam logic signed [YG-1:0] c_y_gnd_g   = YG'(Y_GND);
   localparam logic signed [YG-1:0] c_y_max_g   = YG'((2 ** (YW - 1)) - 1);
   localparam logic signed [YG-1:0] c_vy_min_g  = YG'(-(2 ** (YW - 1)));
   localparam logic signed [YG-1:0] c_g         = YG'(G);

   localparam logic [KW-1:0]        c_kb_ticks  = KW'(KB_TICKS);
   localparam logic [KW-1:0]        c_kcnt_one  = KW'(1);

   typedef enum logic [1:0] {
      ST_GND   = 2'd0,
      ST_AIR   = 2'd1,
      ST_KNOCK = 2'd2
   } state_t;

   state_t                r_state;
   logic signed [XW-1:0]  r_x;
   logic signed [YW-1:0]  r_y;
   logic signed [YW-1:0]  r_vy;
   logic [KW-1:0]         r_kcnt;
   logic                  r_kdir;
   logic                  r_jump_q;
`ifdef DOUBLE_JUMP_EN
   logic                  r_air_used;
`endif

   logic                  w_jump_edge;
   logic                  w_kb_ready;
   logic                  w_kb_hit;
   logic signed [XG-1:0]  w_walk_dx;
   logic signed [XG-1:0]  w_kb_dx;
   logic signed [XW-1:0]  w_x_walk;
   logic signed [XW-1:0]  w_x_kb;
   logic signed [YG-1:0]  w_y_sum;
   logic signed [YG-1:0]  w_vy_dec;
   logic                  w_land;
   logic signed [YW-1:0]  w_y_air;
   logic signed [YW-1:0]  w_vy_air;

   // Clamp a guard-extended x back into the legal range; never wraps.
   function automatic logic signed [XW-1:0] clamp_x(input logic signed [XG-1:0] v);
      if (v < c_x_min_g)
         return c_x_min;
      else if (v > c_x_max_g)
         return c_x_max;
      else
         return v[XW-1:0];
   endfunction

   assign w_jump_edge = bus.jump & ~r_jump_q;
   assign w_kb_ready  = bus.tick & (r_state != ST_KNOCK);
   // A defended transfer completes the handshake but has no effect on motion
   // state; the tick is then processed as a normal control tick.
   assign w_kb_hit    = bus.kb_valid & w_kb_ready & ~bus.defend;

   // Walk displacement: right wins over left; squatting on the ground freezes x.
   always_comb begin
      w_walk_dx = c_zero_xg;
      if (!((r_state == ST_GND) && bus.squat)) begin
         if (bus.right)
            w_walk_dx = c_step_x;
         else if (bus.left)
            w_walk_dx = -c_step_x;
      end
   end

   assign w_kb_dx  = r_kdir ? c_kb_step : -c_kb_step;
   assign w_x_walk = clamp_x(XG'(r_x) + w_walk_dx);
   assign w_x_kb   = clamp_x(XG'(r_x) + w_kb_dx);

   // Ballistic step shared by AIR and KNOCK (gravity acts identically in both).
   assign w_y_sum  = YG'(r_y) + YG'(r_vy);
   assign w_vy_dec = YG'(r_vy) - c_g;
   assign w_land   = (w_y_sum <= c_y_gnd_g);

   always_comb begin
      w_y_air  = c_y_gnd;
      w_vy_air = c_zero_y;
      if (!w_land) begin
         // Upward overflow is saturated as well so y can never wrap negative.
         if (w_y_sum > c_y_max_g)
            w_y_air = c_y_max_g[YW-1:0];
         else
            w_y_air = w_y_sum[YW-1:0];
         if (w_vy_dec < c_vy_min_g)
            w_vy_air = c_vy_min_g[YW-1:0];
         else
            w_vy_air = w_vy_dec[YW-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_GND;
         r_x        <= c_x_min;
         r_y        <= c_y_gnd;
         r_vy       <= c_zero_y;
         r_kcnt     <= '0;
         r_kdir     <= 1'b0;
         r_jump_q   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
         r_air_used <= 1'b0;
`endif
      end else if (bus.tick) begin
         r_jump_q <= bus.jump;
         case (r_state)
            ST_GND: begin
               if (w_kb_hit) begin
                  // Knockback overrides walk and jump; motion starts next tick.
                  r_state <= ST_KNOCK;
                  r_kdir  <= bus.kb_dir;
                  r_kcnt  <= c_kb_ticks;
                  r_y     <= c_y_gnd;
                  r_vy    <= c_zero_y;
               end else begin
                  r_x <= w_x_walk;
                  if (w_jump_edge && !bus.squat) begin
                     r_vy    <= c_v_jump;
                     r_state <= ST_AIR;
                  end else begin
                     r_vy <= c_zero_y;
                     r_y  <= c_y_gnd;
                  end
               end
            end

            ST_AIR: begin
               r_y  <= w_y_air;
               r_vy <= w_vy_air;
               if (w_kb_hit) begin
                  r_state <= ST_KNOCK;
                  r_kdir  <= bus.kb_dir;
                  r_kcnt  <= c_kb_ticks;
               end else begin
                  r_x <= w_x_walk;
                  if (w_land) begin
                     r_state <= ST_GND;
`ifdef DOUBLE_JUMP_EN
                     r_air_used <= 1'b0;
                  end else if (w_jump_edge && !r_air_used) begin
                     // y still advances by the old vy this tick
                     r_vy       <= c_v_jump;
                     r_air_used <= 1'b1;
`endif
                  end
               end
            end

            ST_KNOCK: begin
               r_x    <= w_x_kb;
               r_y    <= w_y_air;
               r_vy   <= w_vy_air;
               r_kcnt <= r_kcnt - 1'b1;
               if (r_kcnt == c_kcnt_one) begin
                  if (w_y_air == c_y_gnd) begin
                     r_state <= ST_GND;
`ifdef DOUBLE_JUMP_EN
                     r_air_used <= 1'b0;
`endif
                  end else begin
                     r_state <= ST_AIR;
                  end
               end
            end

            default: r_state <= ST_GND;
         endcase
      end
   end

   assign bus.kb_ready = w_kb_ready;
   assign bus.x        = r_x;
   assign bus.y        = r_y;
   assign bus.vy       = r_vy;
   assign bus.isJ      = (r_state == ST_AIR) || ((r_state == ST_KNOCK) && (r_y > c_y_gnd));
   assign bus.isQ      = bus.squat & (r_state == ST_GND);
   assign bus.isD      = bus.defend & (r_state != ST_KNOCK);
   assign bus.isK      = (r_state == ST_KNOCK);

endmodule

`default_nettype wire

// File: tb/tb_player_motion.sv
//==============================================================================
// Module      : tb_player_motion
// Description : Directed self-checking bench for player_motion with default
//               parameters. Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_player_motion;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   player_motion_if #(.XW(11), .YW(10)) bus();

   player_motion dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic clear_inputs();
      bus.tick     = 1'b0;
      bus.right    = 1'b0;
      bus.left     = 1'b0;
      bus.jump     = 1'b0;
      bus.squat    = 1'b0;
      bus.defend   = 1'b0;
      bus.kb_valid = 1'b0;
      bus.kb_dir   = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic tick1();
      @(negedge clk);
      bus.tick = 1'b1;
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick1();
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (bus.x !== -300) begin n_err++; $display("FAIL reset_x got %0d want -300", bus.x); end
      n_vec++;
      if (bus.y !== -200 || bus.vy !== 0) begin
         n_err++; $display("FAIL reset_y_vy got y=%0d vy=%0d want -200 0", bus.y, bus.vy);
      end
      n_vec++;
      if ({bus.isJ, bus.isQ, bus.isD, bus.isK, bus.kb_ready} !== 5'b0) begin
         n_err++; $display("FAIL reset_flags got %b want 00000",
                           {bus.isJ, bus.isQ, bus.isD, bus.isK, bus.kb_ready});
      end
      rst_n = 1'b1;
   endtask

   task automatic test_walk_clamp();
      do_reset();
      bus.right = 1'b1;
      ticks(5);
      n_vec++;
      if (bus.x !== -280) begin n_err++; $display("FAIL walk_right5 got %0d want -280", bus.x); end
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (bus.x !== -280) begin n_err++; $display("FAIL hold_no_tick got %0d want -280", bus.x); end
      bus.left = 1'b1;
      tick1();
      n_vec++;
      if (bus.x !== -276) begin n_err++; $display("FAIL right_priority got %0d want -276", bus.x); end
      bus.right = 1'b0;
      ticks(100);
      n_vec++;
      if (bus.x !== -300) begin n_err++; $display("FAIL clamp_left got %0d want -300", bus.x); end
      bus.left  = 1'b0;
      bus.right = 1'b1;
      ticks(160);
      n_vec++;
      if (bus.x !== 300) begin n_err++; $display("FAIL clamp_right got %0d want 300", bus.x); end
      bus.right = 1'b0;
   endtask

   task automatic test_jump();
      int n_land;
      do_reset();
      bus.jump = 1'b1;
      tick1();
      n_vec++;
      if (bus.y !== -200 || bus.vy !== 12 || bus.isJ !== 1'b1) begin
         n_err++; $display("FAIL jump_launch got y=%0d vy=%0d isJ=%b want -200 12 1", bus.y, bus.vy, bus.isJ);
      end
      tick1();
      n_vec++;
      if (bus.y !== -188 || bus.vy !== 11) begin
         n_err++; $display("FAIL jump_tick1 got y=%0d vy=%0d want -188 11", bus.y, bus.vy);
      end
      ticks(11);
      n_vec++;
      if (bus.y !== -122 || bus.vy !== 0) begin
         n_err++; $display("FAIL jump_apex got y=%0d vy=%0d want -122 0", bus.y, bus.vy);
      end
      n_land = 0;
      for (int i = 1; i <= 40; i++) begin
         tick1();
         if (bus.isJ === 1'b0) begin n_land = i; break; end
      end
      n_vec++;
      if (n_land !== 13 || bus.y !== -200 || bus.vy !== 0) begin
         n_err++; $display("FAIL jump_land got ticks_after_apex=%0d y=%0d vy=%0d want 13 -200 0",
                           n_land, bus.y, bus.vy);
      end
      ticks(3);
      n_vec++;
      if (bus.isJ !== 1'b0 || bus.y !== -200) begin
         n_err++; $display("FAIL held_no_rejump got isJ=%b y=%0d want 0 -200", bus.isJ, bus.y);
      end
      bus.jump = 1'b0;
      tick1();
      bus.jump = 1'b1;
      tick1();
      n_vec++;
      if (bus.isJ !== 1'b1 || bus.vy !== 12) begin
         n_err++; $display("FAIL new_edge_jump got isJ=%b vy=%0d want 1 12", bus.isJ, bus.vy);
      end
      bus.jump = 1'b0;
   endtask

   task automatic test_double_jump();
      int exp_vy2;
      int exp_vy3;
      int n_land;
`ifdef DOUBLE_JUMP_EN
      exp_vy2 = 12;
      exp_vy3 = 10;
`else
      exp_vy2 = 4;
      exp_vy3 = 2;
`endif
      do_reset();
      bus.jump = 1'b1;
      tick1();
      bus.jump = 1'b0;
      ticks(7);
      n_vec++;
      if (bus.y !== -137 || bus.vy !== 5) begin
         n_err++; $display("FAIL dj_pre got y=%0d vy=%0d want -137 5", bus.y, bus.vy);
      end
      bus.jump = 1'b1;
      tick1();
      n_vec++;
      if (bus.y !== -132 || bus.vy !== exp_vy2) begin
         n_err++; $display("FAIL dj_second_edge got y=%0d vy=%0d want -132 %0d", bus.y, bus.vy, exp_vy2);
      end
      bus.jump = 1'b0;
      tick1();
      bus.jump = 1'b1;
      tick1();
      n_vec++;
      if (bus.vy !== exp_vy3) begin
         n_err++; $display("FAIL dj_third_edge got vy=%0d want %0d", bus.vy, exp_vy3);
      end
      bus.jump = 1'b0;
      n_land = 0;
      for (int i = 1; i <= 80; i++) begin
         tick1();
         if (bus.isJ === 1'b0) begin n_land = i; break; end
      end
      n_vec++;
      if (n_land == 0 || bus.y !== -200) begin
         n_err++; $display("FAIL dj_land got landed_after=%0d y=%0d want landing at -200", n_land, bus.y);
      end
   endtask

   task automatic test_squat_and_async_reset();
      do_reset();
      bus.squat = 1'b1;
      bus.right = 1'b1;
      tick1();
      n_vec++;
      if (bus.x !== -300 || bus.isQ !== 1'b1) begin
         n_err++; $display("FAIL squat_freeze got x=%0d isQ=%b want -300 1", bus.x, bus.isQ);
      end
      bus.right = 1'b0;
      bus.jump  = 1'b1;
      tick1();
      n_vec++;
      if (bus.isJ !== 1'b0 || bus.vy !== 0) begin
         n_err++; $display("FAIL squat_blocks_jump got isJ=%b vy=%0d want 0 0", bus.isJ, bus.vy);
      end
      bus.squat = 1'b0;
      bus.jump  = 1'b0;
      tick1();
      bus.jump = 1'b1;
      tick1();
      bus.squat = 1'b1;
      ticks(3);
      #1;
      n_vec++;
      if (bus.isQ !== 1'b0 || bus.isJ !== 1'b1) begin
         n_err++; $display("FAIL squat_in_air got isQ=%b isJ=%b want 0 1", bus.isQ, bus.isJ);
      end
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.y !== -200 || bus.vy !== 0 || bus.x !== -300 || bus.isJ !== 1'b0 || bus.isK !== 1'b0) begin
         n_err++; $display("FAIL async_reset got x=%0d y=%0d vy=%0d isJ=%b isK=%b want -300 -200 0 0 0",
                           bus.x, bus.y, bus.vy, bus.isJ, bus.isK);
      end
      clear_inputs();
      @(negedge clk) rst_n = 1'b1;
   endtask

   task automatic test_knockback();
      do_reset();
      bus.right = 1'b1;
      ticks(75);
      bus.right = 1'b0;
      n_vec++;
      if (bus.x !== 0) begin n_err++; $display("FAIL kb_setup got x=%0d want 0", bus.x); end
      @(negedge clk);
      bus.tick     = 1'b1;
      bus.kb_valid = 1'b1;
      bus.kb_dir   = 1'b1;
      #1;
      n_vec++;
      if (bus.kb_ready !== 1'b1) begin n_err++; $display("FAIL kb_ready_idle got %b want 1", bus.kb_ready); end
      @(posedge clk);
      #1;
      bus.tick     = 1'b0;
      bus.kb_valid = 1'b0;
      n_vec++;
      if (bus.isK !== 1'b1 || bus.x !== 0) begin
         n_err++; $display("FAIL kb_accept got isK=%b x=%0d want 1 0", bus.isK, bus.x);
      end
      // Controls must be ignored while knocked back
      bus.left = 1'b1;
      @(negedge clk);
      bus.tick = 1'b1;
      #1;
      n_vec++;
      if (bus.kb_ready !== 1'b0) begin n_err++; $display("FAIL kb_ready_busy got %b want 0", bus.kb_ready); end
      @(posedge clk);
      #1;
      bus.tick = 1'b0;
      n_vec++;
      if (bus.x !== 6) begin n_err++; $display("FAIL kb_first_step got x=%0d want 6", bus.x); end
      ticks(7);
      n_vec++;
      if (bus.x !== 48 || bus.isK !== 1'b0 || bus.isJ !== 1'b0 || bus.y !== -200) begin
         n_err++; $display("FAIL kb_done got x=%0d isK=%b isJ=%b y=%0d want 48 0 0 -200",
                           bus.x, bus.isK, bus.isJ, bus.y);
      end
      bus.left = 1'b0;
      @(negedge clk);
      bus.tick = 1'b1;
      #1;
      n_vec++;
      if (bus.kb_ready !== 1'b1) begin n_err++; $display("FAIL kb_ready_return got %b want 1", bus.kb_ready); end
      @(posedge clk);
      #1;
      bus.tick   = 1'b0;
      bus.kb_dir = 1'b0;
   endtask

   task automatic test_blocked();
      do_reset();
      bus.right = 1'b1;
      ticks(75);
      bus.right  = 1'b0;
      bus.defend = 1'b1;
      @(negedge clk);
      bus.tick     = 1'b1;
      bus.kb_valid = 1'b1;
      bus.kb_dir   = 1'b1;
      #1;
      n_vec++;
      if (bus.kb_ready !== 1'b1 || bus.isD !== 1'b1) begin
         n_err++; $display("FAIL block_handshake got kb_ready=%b isD=%b want 1 1", bus.kb_ready, bus.isD);
      end
      @(posedge clk);
      #1;
      bus.tick     = 1'b0;
      bus.kb_valid = 1'b0;
      bus.defend   = 1'b0;
      ticks(2);
      n_vec++;
      if (bus.isK !== 1'b0 || bus.x !== 0) begin
         n_err++; $display("FAIL block_no_effect got isK=%b x=%0d want 0 0", bus.isK, bus.x);
      end
   endtask

   initial begin
      test_reset();
      test_walk_clamp();
      test_jump();
      test_double_jump();
      test_squat_and_async_reset();
      test_knockback();
      test_blocked();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout vectors=%0d", n_vec);
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/player_motion.md
# player_motion

Per-player kinematics engine for the fighting-game control path, and the parametrised successor of the fixed single-player controller. It owns one player's position and vertical velocity, advances physics once per frame tick, and handles walking, jumping, squatting, defending and knockback. Output feeds the renderer and hit-detection logic. Instantiate once per player.

## Interface
- XW, 11: signed width of x.
- YW, 10: signed width of y and vy.
- X_MIN, -300: leftmost legal x.
- X_MAX, 300: rightmost legal x.
- Y_GND, -200: ground y. y increases upward.
- STEP_X, 4: walk displacement per tick.
- V_JUMP, 12: initial upward vy on a jump.
- G, 1: vy decrement per airborne tick.
- KB_STEP, 6: x displacement per knockback tick.
- KB_TICKS, 8: knockback duration in ticks, at least 1.
- Reset is `rst_n`, asynchronous and active-low. The clock is `clk`.
- clk  in  1  system clock.
- rst_n  in  1  async active-low reset.
- tick  in  1  one-cycle frame strobe. All physics updates occur only on clocks with tick=1.
- right, left, jump, squat, defend  in  1  each  level controls, sampled on tick.
- kb_valid  in  1  knockback request.
- kb_dir  in  1  knockback direction: 1 pushes toward +x.
- kb_ready  out  1  knockback accept.
- x  out  XW  signed position.
- y  out  YW  signed position.
- vy  out  YW  signed vertical velocity.
- isJ, isQ, isD, isK  out  1  each  airborne, squatting, defending, knocked-back.

## Operation
- States:
  - GND: on the ground.
  - AIR: airborne.
  - KNOCK: in knockback, with a down-counter kcnt.
- Reset values: x=X_MIN, y=Y_GND, vy=0, state GND, kcnt=0. All flag outputs are 0. The jump-edge register is 0.
- jump_edge = jump & ~jump_q. jump_q is updated on every tick only.
- Horizontal movement in GND or AIR:
  - right adds STEP_X.
  - Otherwise, left subtracts STEP_X.
  - right has priority over left.
  - In GND, no horizontal movement occurs while squat=1.
- Horizontal clamp: x_next is computed with one extra guard bit and then clamped to [X_MIN, X_MAX]. The result never wraps.
- GND state:
  - On jump_edge with squat=0: vy←V_JUMP, then go to AIR.
  - Otherwise vy=0 and y=Y_GND.
- AIR state, per tick:
  - y_next = y + vy, computed with a guard bit.
  - vy_next = vy − G.
  - If y_next ≤ Y_GND: y←Y_GND, vy←0, go to GND. Landing takes priority over any jump.
  - If vy_next would drop below −2^(YW−1), it saturates at that value.
- KNOCK state, per tick:
  - x moves ±KB_STEP according to the latched direction, clamped as above.
  - kcnt decrements. When kcnt reaches 0, go to GND if y==Y_GND, else AIR.
  - Gravity continues to apply exactly as in AIR, and landing sets y=Y_GND while staying in KNOCK.
  - right, left, jump, squat and defend are ignored.
- Knockback handshake:
  - kb_ready = tick & (state≠KNOCK).
  - A transfer happens when kb_valid & kb_ready.
  - On transfer with defend=1 (blocked): no state change and no motion.
  - On transfer with defend=0: latch kb_dir, set kcnt←KB_TICKS, go to KNOCK. Knockback motion starts on the next tick.
  - On a transfer tick, the knockback overrides that tick's walk and jump. Gravity still applies.
- Flag outputs:
  - isJ = (state==AIR), or (KNOCK with y>Y_GND).
  - isQ = squat & (state==GND).
  - isD = defend & (state≠KNOCK).
  - isK = (state==KNOCK).
- Reset asserted mid-jump or mid-knockback returns all state to the reset values immediately.

## Timing
- All outputs are registered. They change only on the cycle after a tick, giving 1-tick latency from control inputs to x, y and vy.
- Cycles with tick=0 hold all state. The bench must not rely on multi-cycle ticks.
- Flags isQ and isD follow their inputs combinationally, gated by registered state.
- kb_ready is combinational from tick and state.

## Configuration
- DOUBLE_JUMP_EN defined:
  - One extra jump per airborne period. In AIR, jump_edge with the air-jump-used flag clear sets vy←V_JUMP and sets the flag.
  - The flag clears on entry to GND and on reset.
  - Landing in the same tick takes priority over the air jump.
- DOUBLE_JUMP_EN undefined: jump in AIR is ignored. The flag logic is absent.

## Test plan
- Reset, then 5 ticks with right=1: x = −300+20 = −280. Then hold left for 100 ticks: x clamps at −300, with no wrap.
- Jump from ground with defaults: after tick 1, y=−188 and vy=11. Apex is y=−122 after 12 ticks. Landing is back at y=−200 with state GND, isJ=0, after 25 ticks. Holding jump gives no re-jump without a new edge.
- kb_valid=1 with kb_dir=1 and defend=0 at x=0: kb_ready=1 and isK=1 the next cycle. After 8 ticks x=48, then isK drops and kb_ready returns on ticks.
- Same knockback request with defend=1: handshake completes, x is unchanged, isK stays 0.
- Second jump edge mid-air at vy=5:
  - With DOUBLE_JUMP_EN, vy resets to 12; a third edge is ignored.
  - Without DOUBLE_JUMP_EN, vy continues to 4.
- squat=1 with right=1 on ground: x is unchanged and isQ=1. Squat during AIR gives isQ=0. Async reset mid-jump gives y=−200 and state GND.
